// File: rtl/snowball_mem_arbiter.sv
// snowball_mem_arbiter: N-channel requester arbiter onto a single DDR user port.
// Round-robin or fixed priority, one outstanding transaction, optional watchdog.
module snowball_mem_arbiter #(
  parameter int N_CH    = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int RR_MODE = 1,
  parameter int TIMEOUT = 1023
) (
  input  logic                     MCU_CLK,
  input  logic                     RST,
  input  logic [N_CH-1:0]          ch_req,
  input  logic [N_CH-1:0]          ch_we,
  input  logic [N_CH*ADDR_W-1:0]   ch_addr,
  input  logic [N_CH*DATA_W-1:0]   ch_datain,
  output logic [N_CH-1:0]          ch_ack,
  output logic [DATA_W-1:0]        ch_dataout,
  output logic                     err_timeout,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic                     mem_we,
  output logic                     mem_do_act,
  output logic [DATA_W-1:0]        mem_dataintomem,
  input  logic                     mem_ack,
  input  logic [DATA_W-1:0]        mem_datafrommem
);

  localparam int IDX_W = $clog2(N_CH);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit WD_ON = (TIMEOUT > 0);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_CH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            nxt_state;
  logic [IDX_W-1:0]  grant;
  logic [IDX_W-1:0]  nxt_grant;
  logic [IDX_W-1:0]  last_grant;
  logic [IDX_W-1:0]  nxt_last;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  nxt_cnt;
  logic [N_CH-1:0]   nxt_ack;
  logic [DATA_W-1:0] nxt_dout;
  logic              nxt_err;
  logic [ADDR_W-1:0] nxt_addr;
  logic              nxt_we;
  logic              nxt_act;
  logic [DATA_W-1:0] nxt_wdata;

  logic              arb_any;
  logic [IDX_W-1:0]  arb_pick;

  // Pick the winning requester: first set bit scanning from the rotating start.
  always_comb begin : arb
    int c;
    c        = 0;
    arb_any  = 1'b0;
    arb_pick = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (RR_MODE != 0) begin
        c = (int'(last_grant) + 1 + i) % N_CH;
      end else begin
        c = i;
      end
      if (!arb_any && ch_req[c]) begin
        arb_any  = 1'b1;
        arb_pick = IDX_W'(c);
      end
    end
  end

  // Next-state and next-output logic for the IDLE/WAIT/DONE sequencer.
  always_comb begin
    nxt_state = state;
    nxt_grant = grant;
    nxt_last  = last_grant;
    nxt_cnt   = cnt;
    nxt_ack   = '0;
    nxt_dout  = ch_dataout;
    nxt_err   = err_timeout;
    nxt_addr  = mem_addr;
    nxt_we    = mem_we;
    nxt_act   = mem_do_act;
    nxt_wdata = mem_dataintomem;
    unique case (state)
      IDLE: begin
        if (arb_any) begin
          nxt_state = WAIT;
          nxt_grant = arb_pick;
          nxt_last  = arb_pick;
          nxt_cnt   = '0;
          nxt_addr  = ch_addr[arb_pick*ADDR_W +: ADDR_W];
          nxt_we    = ch_we[arb_pick];
          nxt_wdata = ch_datain[arb_pick*DATA_W +: DATA_W];
          nxt_act   = 1'b1;
        end
      end
      WAIT: begin
        if (mem_ack) begin
          nxt_state      = DONE;
          nxt_act        = 1'b0;
          nxt_ack[grant] = 1'b1;
          nxt_dout       = mem_datafrommem;
        end else if (WD_ON && (cnt == CNT_MAX)) begin
          nxt_state      = DONE;
          nxt_act        = 1'b0;
          nxt_ack[grant] = 1'b1;
          nxt_dout       = '1;
          nxt_err        = 1'b1;
        end else if (WD_ON) begin
          nxt_cnt = cnt + CNT_W'(1);
        end
      end
      DONE: begin
        nxt_state = IDLE;
      end
      default: begin
        nxt_state = IDLE;
      end
    endcase
  end

  // State, arbitration history, watchdog and registered outputs.
  always_ff @(posedge MCU_CLK) begin
    if (RST) begin
      state           <= IDLE;
      grant           <= '0;
      last_grant      <= LAST_RST;
      cnt             <= '0;
      ch_ack          <= '0;
      ch_dataout      <= '0;
      err_timeout     <= 1'b0;
      mem_addr        <= '0;
      mem_we          <= 1'b0;
      mem_do_act      <= 1'b0;
      mem_dataintomem <= '0;
    end else begin
      state           <= nxt_state;
      grant           <= nxt_grant;
      last_grant      <= nxt_last;
      cnt             <= nxt_cnt;
      ch_ack          <= nxt_ack;
      ch_dataout      <= nxt_dout;
      err_timeout     <= nxt_err;
      mem_addr        <= nxt_addr;
      mem_we          <= nxt_we;
      mem_do_act      <= nxt_act;
      mem_dataintomem <= nxt_wdata;
    end
  end

endmodule

// File: tb/tb_snowball_mem_arbiter.sv
// tb_snowball_mem_arbiter: randomized bench with a transaction-level model.
// Instance 0 is round-robin with an 8-cycle watchdog, instance 1 fixed priority, no watchdog.
module tb_snowball_mem_arbiter;

  localparam int NC = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int T0 = 8;
  localparam int T1 = 0;

  logic clk = 1'b0;
  logic rst;

  logic [NC-1:0]    req   [2];
  logic [NC-1:0]    we    [2];
  logic [NC-1:0]    ack   [2];
  logic [NC*AW-1:0] addr  [2];
  logic [NC*DW-1:0] din   [2];
  logic [DW-1:0]    dout  [2];
  logic [DW-1:0]    mdin  [2];
  logic [DW-1:0]    mrd   [2];
  logic [AW-1:0]    maddr [2];
  logic             err   [2];
  logic             mwe   [2];
  logic             mact  [2];
  logic             mack  [2];

  bit            pend   [2][NC];
  bit            m_we   [2][NC];
  logic [AW-1:0] m_addr [2][NC];
  logic [DW-1:0] m_data [2][NC];
  int            last   [2];
  bit            err_m  [2];
  logic [DW-1:0] dout_m [2];

  int checks;
  int errors;

  snowball_mem_arbiter #(
    .N_CH(NC), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1), .TIMEOUT(T0)
  ) u_rr (
    .MCU_CLK(clk), .RST(rst),
    .ch_req(req[0]), .ch_we(we[0]), .ch_addr(addr[0]), .ch_datain(din[0]),
    .ch_ack(ack[0]), .ch_dataout(dout[0]), .err_timeout(err[0]),
    .mem_addr(maddr[0]), .mem_we(mwe[0]), .mem_do_act(mact[0]),
    .mem_dataintomem(mdin[0]), .mem_ack(mack[0]), .mem_datafrommem(mrd[0])
  );

  snowball_mem_arbiter #(
    .N_CH(NC), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(0), .TIMEOUT(T1)
  ) u_fp (
    .MCU_CLK(clk), .RST(rst),
    .ch_req(req[1]), .ch_we(we[1]), .ch_addr(addr[1]), .ch_datain(din[1]),
    .ch_ack(ack[1]), .ch_dataout(dout[1]), .err_timeout(err[1]),
    .mem_addr(maddr[1]), .mem_we(mwe[1]), .mem_do_act(mact[1]),
    .mem_dataintomem(mdin[1]), .mem_ack(mack[1]), .mem_datafrommem(mrd[1])
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int tmo(input int d);
    return (d == 0) ? T0 : T1;
  endfunction

  // Reference arbitration: who should win given the pending set.
  function automatic int exp_grant(input int d);
    if (d == 1) begin
      for (int c = 0; c < NC; c++)
        if (pend[d][c]) return c;
    end else begin
      for (int i = 1; i <= NC; i++)
        if (pend[d][(last[d] + i) % NC]) return (last[d] + i) % NC;
    end
    return -1;
  endfunction

  task automatic drive(input int d);
    for (int c = 0; c < NC; c++) begin
      req[d][c] = pend[d][c];
      we[d][c]  = m_we[d][c];
      addr[d][c*AW +: AW] = m_addr[d][c];
      din[d][c*DW +: DW]  = m_data[d][c];
    end
  endtask

  task automatic set_ch(input int d, input int c, input logic [AW-1:0] a,
                        input bit w, input logic [DW-1:0] v);
    pend[d][c]   = 1'b1;
    m_addr[d][c] = a;
    m_we[d][c]   = w;
    m_data[d][c] = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mack[0] = 1'b0;
    mack[1] = 1'b0;
    tick();
    for (int d = 0; d < 2; d++) begin
      chk("rst_ack", ack[d], 0);
      chk("rst_dout", dout[d], 0);
      chk("rst_err", err[d], 0);
      chk("rst_addr", maddr[d], 0);
      chk("rst_we", mwe[d], 0);
      chk("rst_act", mact[d], 0);
      chk("rst_wdata", mdin[d], 0);
    end
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      last[d]   = NC - 1;
      err_m[d]  = 1'b0;
      dout_m[d] = '0;
      for (int c = 0; c < NC; c++) pend[d][c] = 1'b0;
      drive(d);
    end
  endtask

  // One arbitration plus its memory transaction; r = cycles before mem_ack.
  task automatic do_txn(input int d, input int r, input logic [DW-1:0] rd,
                        input bit drop, input bit rnd);
    int g;
    int n;
    bit abort;
    logic [AW-1:0] a;
    logic [DW-1:0] w;
    bit wb;
    logic [NC-1:0] oh;
    g = exp_grant(d);
    drive(d);
    if (g < 0) begin
      mack[d] = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      mrd[d]  = $urandom;
      tick();
      mack[d] = 1'b0;
      chk("idle_act", mact[d], 0);
      chk("idle_ack", ack[d], 0);
      chk("idle_dout", dout[d], dout_m[d]);
      return;
    end
    a  = m_addr[d][g];
    w  = m_data[d][g];
    wb = m_we[d][g];
    tick();
    chk("act", mact[d], 1);
    chk("addr", maddr[d], a);
    chk("we", mwe[d], wb);
    chk("wdata", mdin[d], w);
    chk("ack_early", ack[d], 0);
    last[d] = g;
    if (rnd && $urandom_range(0, 1) == 1) begin
      m_addr[d][g] = $urandom;
      m_data[d][g] = $urandom;
      m_we[d][g]   = ~m_we[d][g];
    end
    if (rnd && $urandom_range(0, 3) == 0) pend[d][g] = 1'b0;
    drive(d);
    abort = (tmo(d) > 0) && (r > tmo(d));
    n = abort ? tmo(d) : r;
    for (int j = 0; j < n; j++) begin
      tick();
      chk("hold_act", mact[d], 1);
      chk("hold_addr", maddr[d], a);
      chk("hold_we", mwe[d], wb);
      chk("hold_wdata", mdin[d], w);
      chk("hold_ack", ack[d], 0);
    end
    if (!abort) begin
      mack[d] = 1'b1;
      mrd[d]  = rd;
    end
    tick();
    mack[d] = 1'b0;
    mrd[d]  = $urandom;
    if (abort) begin
      err_m[d]  = 1'b1;
      dout_m[d] = '1;
    end else begin
      dout_m[d] = rd;
    end
    oh = '0;
    oh[g] = 1'b1;
    chk("ack", ack[d], oh);
    chk("dout", dout[d], dout_m[d]);
    chk("act_off", mact[d], 0);
    chk("err", err[d], err_m[d]);
    if (drop) pend[d][g] = 1'b0;
    drive(d);
    if (rnd) mack[d] = 1'($urandom_range(0, 1));
    tick();
    mack[d] = 1'b0;
    chk("done_ack", ack[d], 0);
    chk("done_act", mact[d], 0);
    chk("dout_hold", dout[d], dout_m[d]);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    for (int d = 0; d < 2; d++) begin
      mack[d] = 1'b0;
      mrd[d]  = '0;
      for (int c = 0; c < NC; c++) begin
        pend[d][c]   = 1'b0;
        m_we[d][c]   = 1'b0;
        m_addr[d][c] = '0;
        m_data[d][c] = '0;
      end
      drive(d);
    end
    do_reset();

    // single read on channel 0
    set_ch(0, 0, 32'h100, 1'b0, 32'h0);
    do_txn(0, 5, 32'hDEADBEEF, 1'b1, 1'b0);

    // write path on channel 1
    set_ch(0, 1, 32'h40, 1'b1, 32'h12345678);
    do_txn(0, 3, 32'h0BAD0BAD, 1'b1, 1'b0);

    // round-robin contention, all held, immediate acks
    do_reset();
    for (int c = 0; c < NC; c++)
      set_ch(0, c, 32'h1000 + 32'(c), 1'b0, 32'hA0 + 32'(c));
    for (int t = 0; t < 5; t++)
      do_txn(0, 0, 32'hC0DE0000 + 32'(t), 1'b0, 1'b0);
    for (int c = 0; c < NC; c++) pend[0][c] = 1'b0;

    // watchdog expiry, then sticky flag across a clean transaction
    do_reset();
    set_ch(0, 2, 32'h200, 1'b0, 32'h0);
    do_txn(0, 20, 32'h0, 1'b1, 1'b0);
    set_ch(0, 3, 32'h300, 1'b0, 32'h0);
    do_txn(0, 8, 32'h55AA55AA, 1'b1, 1'b0);
    set_ch(0, 1, 32'h310, 1'b0, 32'h0);
    do_txn(0, 1, 32'h01234567, 1'b1, 1'b0);

    // reset while waiting on memory
    set_ch(0, 2, 32'h400, 1'b0, 32'h0);
    drive(0);
    tick();
    chk("r41_act", mact[0], 1);
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("r41_wait_ack", ack[0], 0);
    end
    do_reset();
    mack[0] = 1'b1;
    mrd[0]  = 32'hFEEDFACE;
    tick();
    mack[0] = 1'b0;
    chk("r41_stray_ack", ack[0], 0);
    chk("r41_stray_act", mact[0], 0);
    chk("r41_stray_dout", dout[0], 0);
    set_ch(0, 0, 32'h500, 1'b0, 32'h0);
    set_ch(0, 2, 32'h520, 1'b0, 32'h0);
    do_txn(0, 2, 32'h600DF00D, 1'b1, 1'b0);
    do_txn(0, 2, 32'h600DF00E, 1'b1, 1'b0);

    // fixed priority: channel 1 starves channel 2 until it drops
    set_ch(1, 1, 32'h11, 1'b0, 32'h0);
    set_ch(1, 2, 32'h22, 1'b1, 32'hBEEF);
    for (int t = 0; t < 3; t++)
      do_txn(1, t, 32'h77000000 + 32'(t), 1'b0, 1'b0);
    do_txn(1, 1, 32'h77000010, 1'b1, 1'b0);
    do_txn(1, 0, 32'h77000020, 1'b1, 1'b0);
    set_ch(1, 3, 32'h33, 1'b0, 32'h0);
    do_txn(1, 15, 32'h77000030, 1'b1, 1'b0);

    // randomized traffic on both arbiters
    for (int d = 0; d < 2; d++) begin
      for (int t = 0; t < 80; t++) begin
        if ($urandom_range(0, 2) != 0) begin
          for (int c = 0; c < NC; c++)
            if (!pend[d][c] && $urandom_range(0, 1) == 1)
              set_ch(d, c, $urandom, 1'($urandom_range(0, 1)), $urandom);
        end
        do_txn(d, (d == 0) ? $urandom_range(0, 10) : $urandom_range(0, 12),
               $urandom, $urandom_range(0, 3) != 0, 1'b1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
